// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered UART transmitter, 8 data bits, 1 stop bit, LSB first.
// A circular FIFO feeds a frame FSM that paces bits at DIVISOR clocks per bit.
// Optional even parity bit after the data bits: define UART_TX_PARITY_EN.
module uart_tx_buffered #(
    parameter int DIVISOR    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tx_en,
    input  logic [7:0]                       tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             tx,
    output logic                             busy,
    output logic                             char_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          LW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] BAUD_LAST = 16'(DIVISOR - 1);
    localparam logic [15:0] BAUD_PRE  = 16'(DIVISOR - 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    // Even parity: the parity bit makes the XOR over data plus parity zero.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [7:0]  fifo_mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic        bit_last_s;
    logic [7:0]  head_s;

    state_t      state_r;
    logic [15:0] baud_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign tx_ready   = !full_s;
    assign push_s     = tx_valid && !full_s;
    assign fifo_level = LW'(wr_ptr_r - rd_ptr_r);
    assign head_s     = fifo_mem_r[rd_ptr_r[AW-1:0]];
    assign bit_last_s = (baud_cnt_r == BAUD_LAST);

    // Launch condition: idle, or the last cycle of a stop bit, with data and enable.
    always_comb begin
        pop_s = 1'b0;
        if (tx_en && !empty_s) begin
            if (state_r == S_IDLE) begin
                pop_s = 1'b1;
            end else if ((state_r == S_STOP) && bit_last_s) begin
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= tx_data;
        end
    end

    // FIFO pointers; a push and a pop on the same edge both take effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Frame FSM with registered line, busy and char_done; tx holds the value of the bit being sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            char_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            // Registered one cycle early so the pulse lands on the last stop cycle.
            char_done <= (state_r == S_STOP) && (baud_cnt_r == BAUD_PRE);
            case (state_r)
                S_IDLE: begin
                    baud_cnt_r <= 16'd0;
                    bit_cnt_r  <= 3'd0;
                    if (pop_s) begin
                        shift_r <= head_s;
`ifdef UART_TX_PARITY_EN
                        parity_r <= even_parity(head_s);
`endif
                        state_r <= S_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_last_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_cnt_r  <= 3'd0;
                        state_r    <= S_DATA;
                        tx         <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_last_s) begin
                        baud_cnt_r <= 16'd0;
                        shift_r    <= {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_r   <= S_PARITY;
                            tx        <= parity_r;
`else
                            state_r   <= S_STOP;
                            tx        <= 1'b1;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            tx        <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_last_s) begin
                        baud_cnt_r <= 16'd0;
                        state_r    <= S_STOP;
                        tx         <= 1'b1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_last_s) begin
                        baud_cnt_r <= 16'd0;
                        if (pop_s) begin
                            shift_r <= head_s;
`ifdef UART_TX_PARITY_EN
                            parity_r <= even_parity(head_s);
`endif
                            state_r <= S_START;
                            tx      <= 1'b0;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    baud_cnt_r <= 16'd0;
                    bit_cnt_r  <= 3'd0;
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed bench for uart_tx_buffered (DIVISOR=16, FIFO_DEPTH=8).
// Honours UART_TX_PARITY_EN to expect 11-bit frames with even parity.
module tb_uart_tx_buffered;
    localparam int D = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * D;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       char_done;
    logic [3:0] fifo_level;

    int checks;
    int errors;

    uart_tx_buffered #(.DIVISOR(D), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .char_done  (char_done),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit index idx of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if ((NBITS == 11) && (idx == 9)) return ^b;
        return 1'b1;
    endfunction

    // Called at the negedge of frame cycle 0; returns at the negedge of cycle FL-1.
    task automatic frame_check(input logic [7:0] b, input int drop_at);
        for (int c = 0; c < FL; c++) begin
            if (c > 0) tick();
            chk($sformatf("tx_b%0h_c%0d", b, c), {7'd0, tx}, {7'd0, exp_bit(b, c / D)});
            chk($sformatf("cdone_b%0h_c%0d", b, c), {7'd0, char_done}, {7'd0, (c == FL - 1)});
            chk($sformatf("busy_b%0h_c%0d", b, c), {7'd0, busy}, 8'd1);
            if (c == drop_at) tx_en = 1'b0;
        end
    endtask

    task automatic idle_check(input string tag, input logic [3:0] lvl);
        chk({tag, "_tx"}, {7'd0, tx}, 8'd1);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_level"}, {4'd0, fifo_level}, {4'd0, lvl});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        tx_en    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Reset state
        idle_check("reset", 4'd0);
        chk("reset_cdone", {7'd0, char_done}, 8'd0);
        chk("reset_ready", {7'd0, tx_ready}, 8'd1);

        // Single byte 0x41
        tx_en = 1'b1; tx_data = 8'h41; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("single_level_pre", {4'd0, fifo_level}, 8'd1);
        chk("single_tx_pre", {7'd0, tx}, 8'd1);
        tick();
        chk("single_level_pop", {4'd0, fifo_level}, 8'd0);
        frame_check(8'h41, -1);
        tick();
        idle_check("single_after", 4'd0);

        // Burst 0x00..0x09 with continuous push
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int guard;
                    guard = 0;
                    tx_data = 8'(i); tx_valid = 1'b1;
                    while (!tx_ready && guard < 1000) begin
                        tick();
                        guard++;
                    end
                    if (guard >= 1000) chk("burst_push_timeout", 8'd1, 8'd0);
                    tick();
                    if (i == 8) begin
                        chk("burst_full_ready", {7'd0, tx_ready}, 8'd0);
                        chk("burst_full_level", {4'd0, fifo_level}, 8'd8);
                    end
                end
                tx_valid = 1'b0;
            end
            begin
                int guard;
                guard = 0;
                tick();
                while (tx !== 1'b0 && guard < 50) begin
                    tick();
                    guard++;
                end
                chk("burst_start_seen", {7'd0, tx}, 8'd0);
                for (int k = 0; k < 10; k++) begin
                    if (k > 0) tick();
                    frame_check(8'(k), -1);
                end
            end
        join
        tick();
        idle_check("burst_after", 4'd0);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x03 (parity 0) and 0x07 (parity 1)
        tx_data = 8'h03; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        frame_check(8'h03, -1);
        tick();
        idle_check("par03_after", 4'd0);
        tx_data = 8'h07; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        frame_check(8'h07, -1);
        tick();
        idle_check("par07_after", 4'd0);
`endif

        // tx_en gating: drop enable during the 0x55 data bits
        tx_data = 8'h55; tx_valid = 1'b1;
        tick();
        tx_data = 8'hAA;
        tick();
        tx_valid = 1'b0;
        chk("gate_level_c0", {4'd0, fifo_level}, 8'd1);
        frame_check(8'h55, 40);
        tick();
        idle_check("gate_held", 4'd1);
        for (int i = 0; i < 20; i++) tick();
        idle_check("gate_held_late", 4'd1);
        tx_en = 1'b1;
        tick();
        chk("gate_level_pop", {4'd0, fifo_level}, 8'd0);
        frame_check(8'hAA, -1);
        tick();
        idle_check("gate_after", 4'd0);

        // Reset during data bit 3 of 0x5A with two bytes queued
        tx_data = 8'h5A; tx_valid = 1'b1;
        tick();
        tx_data = 8'h01;
        tick();
        tx_data = 8'h02;
        tick();
        tx_valid = 1'b0;
        for (int i = 1; i < 70; i++) tick();
        chk("rst_mid_level_pre", {4'd0, fifo_level}, 8'd2);
        chk("rst_mid_busy_pre", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        idle_check("rst_mid", 4'd0);
        chk("rst_mid_ready", {7'd0, tx_ready}, 8'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i % 20 == 0) idle_check("rst_quiet", 4'd0);
        end

        // Push on the exact edge a stop bit ends, one byte already queued
        tx_data = 8'h22; tx_valid = 1'b1;
        tick();
        tx_data = 8'h33;
        tick();
        tx_valid = 1'b0;
        chk("simul_level_c0", {4'd0, fifo_level}, 8'd1);
        frame_check(8'h22, -1);
        tx_data = 8'h11; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("simul_level", {4'd0, fifo_level}, 8'd1);
        frame_check(8'h33, -1);
        tick();
        frame_check(8'h11, -1);
        tick();
        idle_check("simul_after", 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
